// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, output
// buffer state encoding and the ALU result function.
package alu_arbiter_pkg;

    // ALU opcodes; 3'b110 and 3'b111 also decode as arithmetic right shift.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

    // Widest operand the ALU function supports.
    localparam int unsigned AluMaxWidth = 64;

    // One-entry output buffer occupancy.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } buf_state_e;

    // Computes the ALU result for operands of 'width' bits carried in 64-bit
    // containers (upper bits must be zero). The result is masked to 'width'
    // bits. Shift amount is the full unsigned B, so shifts of 'width' or more
    // saturate to zero (SRL) or to the sign (SRA).
    function automatic logic [AluMaxWidth-1:0] alu_result(
        input logic [2:0]             op,
        input logic [AluMaxWidth-1:0] a,
        input logic [AluMaxWidth-1:0] b,
        input int unsigned            width
    );
        logic [AluMaxWidth-1:0] mask;
        logic [AluMaxWidth-1:0] a_sx;
        logic [AluMaxWidth-1:0] res;

        if (width >= AluMaxWidth) begin
            mask = '1;
        end else begin
            mask = (AluMaxWidth'(1) << width) - AluMaxWidth'(1);
        end

        // Sign-extend A from its own MSB so the 64-bit shift fills correctly.
        a_sx = a[width-1] ? (a | ~mask) : (a & mask);

        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SRL:  res = (a & mask) >> b;
            default: res = AluMaxWidth'($signed(a_sx) >>> b);
        endcase

        return res & mask;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin grant. ptr_i is the index granted last; on a tie the
// other requester wins. Purely combinational.
module alu_rr_pick (
    input  logic [1:0] req_valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    // Select the winner from the valid mask and the last-grant pointer.
    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = 1'b0;
        unique case (req_valid_i)
            2'b01: begin
                grant_o    = 2'b01;
                grant_id_o = 1'b0;
            end
            2'b10: begin
                grant_o    = 2'b10;
                grant_id_o = 1'b1;
            end
            2'b11: begin
                grant_id_o = ~ptr_i;
                grant_o    = ptr_i ? 2'b01 : 2'b10;
            end
            default: begin
                grant_o    = 2'b00;
                grant_id_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter. The result is
// held in a one-entry output buffer that can drain and refill in one cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] op_cnt
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    logic [1:0]             grant;
    logic                   grant_id;
    logic                   can_accept;
    logic                   accept;
    logic                   drain;
    logic [2:0]             op_sel;
    logic [WIDTH-1:0]       a_sel;
    logic [WIDTH-1:0]       b_sel;
    logic [AluMaxWidth-1:0] alu_full;
    logic                   unused_alu_full;

    alu_rr_pick u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_id_o  (grant_id)
    );

    // Handshake: only the grantee sees ready, and only while the buffer can
    // take a new entry. Held low during reset so nothing is accepted.
    always_comb begin
        can_accept = (state_q == StEmpty) || rsp_ready;
        req_ready  = rst_n ? (grant & {2{can_accept}}) : 2'b00;
        accept     = |req_ready;
        drain      = (state_q == StFull) && rsp_ready;
    end

    // Route the grantee's operands into the shared ALU.
    always_comb begin
        op_sel          = grant_id ? req1_op : req0_op;
        a_sel           = grant_id ? req1_a : req0_a;
        b_sel           = grant_id ? req1_b : req0_b;
        alu_full        = alu_result(op_sel, AluMaxWidth'(a_sel), AluMaxWidth'(b_sel), WIDTH);
        // Bits above WIDTH are always zero after masking.
        unused_alu_full = ^alu_full;
    end

    // Next-state for the output buffer, pointer and completion counter.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        ptr_d      = ptr_q;
        op_cnt_d   = op_cnt_q;

        if (accept) begin
            state_d    = StFull;
            rsp_data_d = alu_full[WIDTH-1:0];
            rsp_id_d   = grant_id;
            ptr_d      = grant_id;
        end else if (drain) begin
            state_d = StEmpty;
        end

        if (drain) begin
            op_cnt_d = op_cnt_q + CNT_W'(1);
        end
    end

    // Buffer FSM and registered outputs; pointer resets to 1 so requester 0
    // wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            ptr_q      <= 1'b1;
            op_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            ptr_q      <= ptr_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        rsp_valid = (state_q == StFull);
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        op_cnt    = op_cnt_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors plus randomized
// traffic compared against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic [CNT_W-1:0] op_cnt;

    int n_checks;
    int n_fail;

    // Reference model state: buffered response and round-robin history.
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_id;
    bit          m_last;
    int unsigned m_cnt;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
            default: begin
                if (b >= 32) return a[31] ? 32'hFFFF_FFFF : 32'd0;
                return 32'($signed(a) >>> b[4:0]);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 1'b0;
        m_last  = 1'b1;
        m_cnt   = 0;
    endtask

    // One clock: compare DUT against model mid-cycle, advance the model,
    // then step past the rising edge. Inputs must already be driven.
    task automatic cycle();
        bit          can;
        bit          gid;
        logic [1:0]  exp_ready;
        @(negedge clk);
        can       = !m_valid || rsp_ready;
        gid       = 1'b0;
        exp_ready = 2'b00;
        if (req_valid == 2'b11) gid = !m_last;
        else if (req_valid == 2'b10) gid = 1'b1;
        if (req_valid != 2'b00 && can) exp_ready = gid ? 2'b10 : 2'b01;

        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check_eq("op_cnt", 64'(op_cnt), 64'(m_cnt % 16));
        if (m_valid) begin
            check_eq("rsp_data", 64'(rsp_data), 64'(m_data));
            check_eq("rsp_id", 64'(rsp_id), 64'(m_id));
        end

        if (m_valid && rsp_ready) m_cnt++;
        if (exp_ready != 2'b00) begin
            m_valid = 1'b1;
            m_data  = gid ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
            m_id    = gid;
            m_last  = gid;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_cnt", 64'(op_cnt), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_op = op;
        req0_a  = a;
        req0_b  = b;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        model_reset();
        #12;
        check_eq("reset_data", 64'(rsp_data), 64'd0);
        check_eq("reset_id", 64'(rsp_id), 64'd0);
        apply_reset();

        // Single add, then drain.
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        drive0(3'b000, 32'd5, 32'd7);
        cycle();
        check_eq("add_valid", 64'(rsp_valid), 64'd1);
        check_eq("add_data", 64'(rsp_data), 64'd12);
        check_eq("add_id", 64'(rsp_id), 64'd0);
        req_valid = 2'b00;
        cycle();
        check_eq("add_cnt", 64'(op_cnt), 64'd1);

        // Both valid: grants alternate starting with requester 0.
        apply_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req1_op = 3'b011; req1_a = 32'h00F0; req1_b = 32'h0F00;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("rr_id", 64'(rsp_id), 64'(i % 2));
            check_eq("rr_valid", 64'(rsp_valid), 64'd1);
        end

        // Stall: 0-1 held while the consumer is not ready.
        req_valid = 2'b01;
        drive0(3'b001, 32'd0, 32'd1);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_data", 64'(rsp_data), 64'hFFFF_FFFF);
            check_eq("stall_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        cycle();

        // Shift saturation cases.
        req_valid = 2'b01;
        drive0(3'b101, 32'h8000_0000, 32'd40);
        cycle();
        check_eq("sra_big", 64'(rsp_data), 64'hFFFF_FFFF);
        drive0(3'b100, 32'h8000_0000, 32'd40);
        cycle();
        check_eq("srl_big", 64'(rsp_data), 64'd0);
        drive0(3'b101, 32'h8000_0000, 32'd4);
        cycle();
        check_eq("sra_4", 64'(rsp_data), 64'hF800_0000);

        // Counter wrap: 17 completions on a 4-bit counter.
        apply_reset();
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        drive0(3'b000, 32'd1, 32'd1);
        for (int i = 0; i < 17; i++) cycle();
        req_valid = 2'b00;
        cycle();
        check_eq("cnt_wrap", 64'(op_cnt), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req0_op = 3'($urandom_range(0, 7));
            req1_op = 3'($urandom_range(0, 7));
            req0_a  = $urandom;
            req1_a  = $urandom;
            req0_b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            req1_b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            cycle();
        end

        // Asynchronous reset while FULL.
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        drive0(3'b000, 32'd3, 32'd4);
        cycle();
        cycle();
        check_eq("pre_rst_valid", 64'(rsp_valid), 64'd1);
        req_valid = 2'b11;
        #2;
        apply_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        cycle();
        check_eq("post_rst_id", 64'(rsp_id), 64'd0);
        req_valid = 2'b00;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/result width; CNT_W, 16, completed-operation counter width.
REQ-002 Clock and reset SHALL be: one clock, clk, rising edge; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; handshake when req_valid[i] && req_ready[i].
REQ-007 req0_op, req1_op  input  3 each  ALU opcode.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-009 rsp_valid  output  1  registered result valid.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  WIDTH  registered ALU result.
REQ-012 rsp_id  output  1  index of requester that issued the result.
REQ-013 op_cnt  output  CNT_W  count of completed responses.

Function
REQ-014 Opcodes SHALL be: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 logical right shift A by B, 101/110/111 arithmetic right shift A by B.
REQ-015 Add/sub SHALL wrap modulo 2^WIDTH, no carry or overflow output.
REQ-016 Shift amount SHALL be the full unsigned B: SRL with B>=WIDTH gives 0; SRA with B>=WIDTH gives all copies of A[WIDTH-1].
REQ-017 Output stage SHALL be a one-entry buffer with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 can_accept SHALL be 1 in EMPTY, and in FULL only when rsp_ready=1 (drain and refill in the same cycle).
REQ-019 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: a single valid requester is granted; with both valid, the requester not last granted wins.
REQ-020 req_ready[i] SHALL be 1 only when requester i is granted and can_accept=1; req_ready SHALL be 0 for non-valid requesters.
REQ-021 At an accepting edge, rsp_data SHALL load the ALU result of the granted operands, rsp_id the grantee, state go FULL, and pointer update to the grantee.
REQ-022 Latency SHALL be exactly 1 cycle: accept at edge N, rsp_valid=1 after edge N.
REQ-023 FULL with rsp_ready=1 and no new accept SHALL go EMPTY at the next edge.
REQ-024 FULL with rsp_ready=0 SHALL hold rsp_data/rsp_id stable and req_ready=0.
REQ-025 op_cnt SHALL increment by 1 on each edge with rsp_valid && rsp_ready, wrapping from 2^CNT_W-1 to 0.
REQ-026 Request inputs SHALL be ignored when not accepted, with no internal latching.

Reset
REQ-027 rst_n low SHALL immediately force: state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, op_cnt=0, pointer=1 (requester 0 wins first tie).
REQ-028 Reset mid-operation SHALL discard any buffered result with no response emitted; req_ready SHALL be 0 while rst_n=0.

Structure
REQ-029 A shared package SHALL hold the opcode constants (OP_ADD..OP_SRA), the EMPTY/FULL state encoding, and the ALU result function.
REQ-030 One sub-module SHALL be used: alu_rr_pick (2-way round-robin grant from req_valid and the pointer, combinational).

Verification
REQ-031 Reset; req_valid=01, op=000, a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=12, rsp_id=0, then op_cnt=1.
REQ-032 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; one result per cycle.
REQ-033 Accept op=001, a=0, b=1, rsp_ready=0 for 3 cycles -> rsp_data=0xFFFFFFFF held stable, req_ready=00 throughout.
REQ-034 op=101, a=0x80000000, b=40 -> 0xFFFFFFFF; op=100, same operands -> 0; op=101, a=0x80000000, b=4 -> 0xF8000000.
REQ-035 CNT_W=4, 17 completed responses -> op_cnt=1.
REQ-036 rst_n pulsed low while FULL -> rsp_valid drops asynchronously, op_cnt=0, first post-reset tie grants requester 0.
